accumulator: RTL and testbench

- Registered running-sum accumulator. Adds an unsigned BITWIDTH-bit input sample into a BITWIDTH+1-bit sum on each enabled clock cycle.
- Provides a synchronous clear and a sticky overflow flag.
- Serves as the generic summing stage behind unary/bit-stream counters and MAC datapaths.
- Single clock domain.

---
 rtl/accumulator.sv | 45 ++++
 tb/tb_accumulator.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/accumulator.sv
// Registered running-sum accumulator with synchronous clear and sticky overflow.
// SATURATE selects between modulo wrap and clamp-at-max on overflow.
module accumulator #(
  parameter int BITWIDTH = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic [BITWIDTH-1:0] iData,
  output logic [BITWIDTH:0]   oData,
  output logic                oOvf
);

  logic [BITWIDTH+1:0] sum;
  logic                carry;
  logic [BITWIDTH:0]   nextData;

  // One extra bit of headroom so the carry-out marks an out-of-range sum.
  always_comb begin
    sum      = {1'b0, oData} + {2'b00, iData};
    carry    = sum[BITWIDTH+1];
    nextData = sum[BITWIDTH:0];
    if (carry && SATURATE) begin
      nextData = '1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oData <= '0;
      oOvf  <= 1'b0;
    end else if (iClr) begin
      oData <= '0;
      oOvf  <= 1'b0;
    end else if (iEn) begin
      oData <= nextData;
      if (carry) begin
        oOvf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accumulator.sv
// Bench for accumulator: wrap and saturate instances share stimulus and are
// checked against an integer reference model plus directed expectations.
module tb_accumulator;

  localparam int BW   = 8;
  localparam int MAXV = (1 << (BW + 1)) - 1;
  localparam int MODV = 1 << (BW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          clr = 1'b0;
  logic [BW-1:0] data = '0;
  logic [BW:0]   dataW, dataS;
  logic          ovfW, ovfS;

  int nCompared   = 0;
  int nMismatched = 0;

  int expW = 0, expS = 0;
  int expOvfW = 0, expOvfS = 0;

  always #5 clk = ~clk;

  accumulator #(.BITWIDTH(BW), .SATURATE(1'b0)) dutWrap (
    .iClk(clk), .iRst(rst), .iEn(en), .iClr(clr), .iData(data),
    .oData(dataW), .oOvf(ovfW)
  );

  accumulator #(.BITWIDTH(BW), .SATURATE(1'b1)) dutSat (
    .iClk(clk), .iRst(rst), .iEn(en), .iClr(clr), .iData(data),
    .oData(dataS), .oOvf(ovfS)
  );

  task automatic checkVal(input string tag, input int obs, input int exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: running integer sum, range-checked against MAXV after each add.
  task automatic modelStep(input bit r, input bit c, input bit e, input int d);
    int s;
    if (r || c) begin
      expW = 0; expS = 0; expOvfW = 0; expOvfS = 0;
    end else if (e) begin
      s = expW + d;
      if (s > MAXV) begin
        expW    = s % MODV;
        expOvfW = 1;
      end else begin
        expW = s;
      end
      s = expS + d;
      if (s > MAXV) begin
        expS    = MAXV;
        expOvfS = 1;
      end else begin
        expS = s;
      end
    end
  endtask

  task automatic stepCycle(input bit r, input bit c, input bit e, input int d);
    rst  = r;
    clr  = c;
    en   = e;
    data = BW'(d);
    @(posedge clk);
    modelStep(r, c, e, d);
    #1;
    checkVal("wrapData", int'(dataW), expW);
    checkVal("wrapOvf",  int'(ovfW),  expOvfW);
    checkVal("satData",  int'(dataS), expS);
    checkVal("satOvf",   int'(ovfS),  expOvfS);
  endtask

  initial begin
    // Reset hold with enable active
    for (int i = 0; i < 2; i++) begin
      stepCycle(1, 0, 1, 10);
      checkVal("rstHoldData", int'(dataW), 0);
      checkVal("rstHoldOvf",  int'(ovfS),  0);
    end

    // Steady accumulate 40 edges
    for (int i = 0; i < 40; i++) begin
      stepCycle(0, 0, 1, 10);
      checkVal("steadyStep", int'(dataW), 10 * (i + 1));
    end
    checkVal("steadyEnd", int'(dataS), 400);
    checkVal("steadyOvf", int'(ovfW), 0);

    // Clear dominates enable
    for (int i = 0; i < 40; i++) begin
      stepCycle(0, 1, 1, 10);
      checkVal("clrHold", int'(dataW), 0);
    end
    stepCycle(0, 0, 1, 10);
    checkVal("clrRelease", int'(dataW), 10);

    // Enable gating from 0: 7, 7, 14, 14
    stepCycle(0, 1, 0, 0);
    stepCycle(0, 0, 1, 7);  checkVal("gate0", int'(dataW), 7);
    stepCycle(0, 0, 0, 7);  checkVal("gate1", int'(dataW), 7);
    stepCycle(0, 0, 1, 7);  checkVal("gate2", int'(dataW), 14);
    stepCycle(0, 0, 0, 7);  checkVal("gate3", int'(dataW), 14);

    // Overflow: build to 500 then add 20
    stepCycle(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) stepCycle(0, 0, 1, 50);
    checkVal("at500", int'(dataW), 500);
    stepCycle(0, 0, 1, 0);
    checkVal("zeroAddData", int'(dataS), 500);
    checkVal("zeroAddOvf",  int'(ovfS),  0);
    stepCycle(0, 0, 1, 20);
    checkVal("wrapTo8",   int'(dataW), 8);
    checkVal("wrapOvfSet", int'(ovfW), 1);
    checkVal("satTo511",  int'(dataS), 511);
    checkVal("satOvfSet", int'(ovfS),  1);
    stepCycle(0, 0, 1, 5);
    checkVal("wrapSticky", int'(ovfW), 1);
    checkVal("satHoldMax", int'(dataS), 511);
    stepCycle(0, 1, 0, 0);
    checkVal("clrOvfW", int'(ovfW), 0);
    checkVal("clrOvfS", int'(ovfS), 0);

    // Reset mid-run after saturation
    for (int i = 0; i < 10; i++) stepCycle(0, 0, 1, 50);
    stepCycle(0, 0, 1, 20);
    stepCycle(0, 0, 1, 5);
    stepCycle(1, 0, 1, 5);
    checkVal("rstMidData", int'(dataS), 0);
    checkVal("rstMidOvf",  int'(ovfS),  0);

    // Randomized traffic biased toward large samples
    for (int i = 0; i < 3000; i++) begin
      bit r, c, e;
      int d;
      r = ($urandom % 64) == 0;
      c = ($urandom % 32) == 0;
      e = ($urandom % 4) != 0;
      case ($urandom % 4)
        0:       d = 0;
        1:       d = int'($urandom_range(200, 255));
        default: d = int'($urandom_range(0, 255));
      endcase
      stepCycle(r, c, e, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
